// File: rtl/spi_byte_slave.sv
// Mode-0 SPI slave byte engine: oversamples SCK/CS_N/MOSI in the clk domain,
// assembles MSB-first words and shifts a one-entry transmit buffer out on MISO.
module spi_byte_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_active,
    output logic [7:0]        byte_count
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   cs_n_dly_q, cs_n_dly_d;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [7:0]        byte_count_q, byte_count_d;
    logic              word_done_q, word_done_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              tx_underrun_q, tx_underrun_d;

    logic sck_s, cs_n_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic start, abort, in_shift, consume;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_fall  = ~cs_n_s & cs_n_dly_q;
    assign cs_rise  = cs_n_s & ~cs_n_dly_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_dly_d   = sck_s;
        cs_n_dly_d  = cs_n_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_n_dly_q  <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_dly_q   <= sck_dly_d;
            cs_n_dly_q  <= cs_n_dly_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_active = (state_q == SHIFT);
        miso         = frame_active & tx_shift_q[DATA_W-1];
    end

    // cs_rise takes priority: any sck edge seen in the same cycle is dropped
    assign start    = (state_q == IDLE) && cs_fall;
    assign abort    = (state_q == SHIFT) && cs_rise;
    assign in_shift = (state_q == SHIFT) && !cs_rise;
    assign consume  = start || (in_shift && sck_fall && word_done_q);

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        byte_count_d  = byte_count_q;
        word_done_d   = word_done_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_underrun_d = 1'b0;

        if (start) begin
            bit_cnt_d    = '0;
            byte_count_d = '0;
            rx_shift_d   = '0;
            word_done_d  = 1'b0;
        end

        if (abort) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
            tx_shift_d  = '0;
        end

        if (in_shift && sck_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                rx_data_d   = {rx_shift_q[DATA_W-2:0], mosi_s};
                rx_valid_d  = 1'b1;
                bit_cnt_d   = '0;
                word_done_d = 1'b1;
                if (byte_count_q != 8'hFF) begin
                    byte_count_d = byte_count_q + 8'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        if (in_shift && sck_fall) begin
            if (word_done_q) begin
                word_done_d = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
        end

        // A load that lands while the buffer is being drained only sticks if it was empty
        if (consume) begin
            tx_shift_d    = tx_full_q ? tx_buf_q : '0;
            tx_underrun_d = !tx_full_q;
        end

        if (consume && tx_full_q) begin
            tx_full_d = 1'b0;
        end else if (tx_load && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            byte_count_q  <= '0;
            word_done_q   <= 1'b0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            byte_count_q  <= byte_count_d;
            word_done_q   <= word_done_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~tx_full_q;
    assign tx_underrun = tx_underrun_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: a bit-banged mode-0 master drives frames
// and checks received words, MISO words, buffer status and underrun pulses.
module tb_spi_byte_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_active;
    logic [7:0] byte_count;

    int checks = 0;
    int passed = 0;

    logic [7:0] rx_q[$];
    int         underrun_cnt = 0;

    spi_byte_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck          (sck),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_ready     (tx_ready),
        .tx_underrun  (tx_underrun),
        .frame_active (frame_active),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    // Collects every received word and underrun pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) underrun_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // One master word: 6 clk low phase, sample MISO, 6 clk high phase
    task automatic spi_word(input logic [7:0] mo, input int nbits, input bit ld,
                            input logic [7:0] lv, output logic [7:0] mi);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[3'(7 - i)];
            if (ld && i == 3) begin
                load_tx(lv);
                wait_clk(5);
            end else begin
                wait_clk(6);
            end
            acc = {acc[6:0], miso};
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
        mi = acc;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        sck     = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (miso !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", miso); else passed++;
        checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); else passed++;
        checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL reset_tx_underrun: got %b expected 0", tx_underrun); else passed++;
        checks++; if (frame_active !== 1'b0) $display("[TB] FAIL reset_frame_active: got %b expected 0", frame_active); else passed++;
        checks++; if (byte_count !== 8'h00) $display("[TB] FAIL reset_byte_count: got %h expected 00", byte_count); else passed++;
    endtask

    task automatic test_single_frame();
        int         rb, ub;
        logic [7:0] mi;
        rb = rx_q.size();
        ub = underrun_cnt;
        load_tx(8'h3C);
        checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL single_ready_after_load: got %b expected 0", tx_ready); else passed++;
        frame_start();
        checks++; if (frame_active !== 1'b1) $display("[TB] FAIL single_frame_active: got %b expected 1", frame_active); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL single_ready_after_start: got %b expected 1", tx_ready); else passed++;
        spi_word(8'hA5, 8, 1'b0, 8'h00, mi);
        frame_end();
        checks++; if (mi !== 8'h3C) $display("[TB] FAIL single_miso: got %h expected 3c", mi); else passed++;
        checks++; if (rx_q.size() - rb != 1) $display("[TB] FAIL single_rx_count: got %0d expected 1", rx_q.size() - rb);
        else begin
            passed++;
            checks++; if (rx_q[rb] !== 8'hA5) $display("[TB] FAIL single_rx_data: got %h expected a5", rx_q[rb]); else passed++;
        end
        checks++; if (byte_count !== 8'd1) $display("[TB] FAIL single_byte_count: got %0d expected 1", byte_count); else passed++;
        // The reload after the last word finds the buffer empty
        checks++; if (underrun_cnt - ub != 1) $display("[TB] FAIL single_underrun: got %0d expected 1", underrun_cnt - ub); else passed++;
        checks++; if (frame_active !== 1'b0) $display("[TB] FAIL single_idle_after: got %b expected 0", frame_active); else passed++;
    endtask

    task automatic test_multi_word();
        int         rb, ub;
        logic [7:0] mi0, mi1, mi2;
        rb = rx_q.size();
        ub = underrun_cnt;
        load_tx(8'h11);
        frame_start();
        spi_word(8'h01, 8, 1'b1, 8'h22, mi0);
        spi_word(8'h80, 8, 1'b0, 8'h00, mi1);
        checks++; if (underrun_cnt - ub != 0) $display("[TB] FAIL multi_underrun_w2: got %0d expected 0", underrun_cnt - ub); else passed++;
        spi_word(8'hFF, 8, 1'b0, 8'h00, mi2);
        checks++; if (underrun_cnt - ub != 1) $display("[TB] FAIL multi_underrun_w3: got %0d expected 1", underrun_cnt - ub); else passed++;
        frame_end();
        checks++; if (mi0 !== 8'h11) $display("[TB] FAIL multi_miso0: got %h expected 11", mi0); else passed++;
        checks++; if (mi1 !== 8'h22) $display("[TB] FAIL multi_miso1: got %h expected 22", mi1); else passed++;
        checks++; if (mi2 !== 8'h00) $display("[TB] FAIL multi_miso2: got %h expected 00", mi2); else passed++;
        checks++; if (rx_q.size() - rb != 3) $display("[TB] FAIL multi_rx_count: got %0d expected 3", rx_q.size() - rb);
        else begin
            passed++;
            checks++; if (rx_q[rb] !== 8'h01) $display("[TB] FAIL multi_rx0: got %h expected 01", rx_q[rb]); else passed++;
            checks++; if (rx_q[rb+1] !== 8'h80) $display("[TB] FAIL multi_rx1: got %h expected 80", rx_q[rb+1]); else passed++;
            checks++; if (rx_q[rb+2] !== 8'hFF) $display("[TB] FAIL multi_rx2: got %h expected ff", rx_q[rb+2]); else passed++;
        end
        checks++; if (byte_count !== 8'd3) $display("[TB] FAIL multi_byte_count: got %0d expected 3", byte_count); else passed++;
        checks++; if (underrun_cnt - ub != 2) $display("[TB] FAIL multi_underrun_end: got %0d expected 2", underrun_cnt - ub); else passed++;
    endtask

    task automatic test_abort();
        int         rb;
        logic [7:0] mi;
        rb = rx_q.size();
        frame_start();
        spi_word(8'hF0, 5, 1'b0, 8'h00, mi);
        frame_end();
        checks++; if (rx_q.size() - rb != 0) $display("[TB] FAIL abort_rx_count: got %0d expected 0", rx_q.size() - rb); else passed++;
        checks++; if (frame_active !== 1'b0) $display("[TB] FAIL abort_idle: got %b expected 0", frame_active); else passed++;
        checks++; if (byte_count !== 8'd0) $display("[TB] FAIL abort_byte_count: got %0d expected 0", byte_count); else passed++;
        frame_start();
        spi_word(8'h5A, 8, 1'b0, 8'h00, mi);
        frame_end();
        checks++; if (rx_q.size() - rb != 1) $display("[TB] FAIL abort_next_count: got %0d expected 1", rx_q.size() - rb);
        else begin
            passed++;
            checks++; if (rx_q[rb] !== 8'h5A) $display("[TB] FAIL abort_next_data: got %h expected 5a", rx_q[rb]); else passed++;
        end
    endtask

    task automatic test_load_ignore();
        logic [7:0] mi;
        load_tx(8'h77);
        checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL ignore_ready1: got %b expected 0", tx_ready); else passed++;
        load_tx(8'h99);
        checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL ignore_ready2: got %b expected 0", tx_ready); else passed++;
        frame_start();
        spi_word(8'h00, 8, 1'b0, 8'h00, mi);
        frame_end();
        checks++; if (mi !== 8'h77) $display("[TB] FAIL ignore_miso: got %h expected 77", mi); else passed++;
    endtask

    task automatic test_load_at_cs_fall();
        int         ub;
        logic [7:0] mi0, mi1;
        ub = underrun_cnt;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL csload_ready_pre: got %b expected 1", tx_ready); else passed++;
        // Two synchronizer stages: cs_fall is acted on at the third rising edge
        cs_n = 1'b0;
        wait_clk(2);
        tx_data = 8'h42;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        wait_clk(3);
        checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL csload_ready_post: got %b expected 0", tx_ready); else passed++;
        spi_word(8'h12, 8, 1'b0, 8'h00, mi0);
        checks++; if (underrun_cnt - ub != 1) $display("[TB] FAIL csload_underrun: got %0d expected 1", underrun_cnt - ub); else passed++;
        spi_word(8'h34, 8, 1'b0, 8'h00, mi1);
        frame_end();
        checks++; if (mi0 !== 8'h00) $display("[TB] FAIL csload_miso0: got %h expected 00", mi0); else passed++;
        checks++; if (mi1 !== 8'h42) $display("[TB] FAIL csload_miso1: got %h expected 42", mi1); else passed++;
    endtask

    task automatic test_reset_mid_word();
        int         rb;
        logic [7:0] mi;
        rb = rx_q.size();
        load_tx(8'hE7);
        frame_start();
        spi_word(8'hC3, 4, 1'b1, 8'hAA, mi);
        checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL midrst_ready_pre: got %b expected 0", tx_ready); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (frame_active !== 1'b0) $display("[TB] FAIL midrst_frame_active: got %b expected 0", frame_active); else passed++;
        checks++; if (byte_count !== 8'd0) $display("[TB] FAIL midrst_byte_count: got %0d expected 0", byte_count); else passed++;
        checks++; if (rx_data !== 8'h00) $display("[TB] FAIL midrst_rx_data: got %h expected 00", rx_data); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL midrst_tx_ready: got %b expected 1", tx_ready); else passed++;
        checks++; if (miso !== 1'b0) $display("[TB] FAIL midrst_miso: got %b expected 0", miso); else passed++;
        cs_n = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        checks++; if (rx_q.size() - rb != 0) $display("[TB] FAIL midrst_rx_count: got %0d expected 0", rx_q.size() - rb); else passed++;
        frame_start();
        spi_word(8'hC3, 8, 1'b0, 8'h00, mi);
        frame_end();
        checks++; if (rx_q.size() - rb != 1) $display("[TB] FAIL midrst_next_count: got %0d expected 1", rx_q.size() - rb);
        else begin
            passed++;
            checks++; if (rx_q[rb] !== 8'hC3) $display("[TB] FAIL midrst_next_data: got %h expected c3", rx_q[rb]); else passed++;
        end
        checks++; if (mi !== 8'h00) $display("[TB] FAIL midrst_next_miso: got %h expected 00", mi); else passed++;
        checks++; if (byte_count !== 8'd1) $display("[TB] FAIL midrst_next_byte_count: got %0d expected 1", byte_count); else passed++;
    endtask

    initial begin
        $display("[TB] spi_byte_slave directed bench");
        test_reset();
        test_single_frame();
        test_multi_word();
        test_abort();
        test_load_ignore();
        test_load_at_cs_fall();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
